// File: rtl/instr_encode_pkg.sv
// Shared mnemonic codes, MIPS opcode/funct values and loader state encoding.
package instr_encode_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT,
    OP_SLL, OP_SRL, OP_SRA, OP_JR, OP_JALR,
    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI,
    OP_BEQ, OP_BNE, OP_LW, OP_SW, OP_J, OP_JAL
  } op_e;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [25:0] imm;
  } fields_t;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  function automatic logic [WORD_W-1:0] r_word(logic [5:0] fn, logic [4:0] rs,
                                               logic [4:0] rt, logic [4:0] rd, logic [4:0] sh);
    return {OPC_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [WORD_W-1:0] i_word(logic [5:0] opc, logic [4:0] rs,
                                               logic [4:0] rt, logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [WORD_W-1:0] j_word(logic [5:0] opc, logic [25:0] target);
    return {opc, target};
  endfunction

endpackage

// File: rtl/instr_encode_loader_packer.sv
// Combinational mnemonic + fields -> 32-bit MIPS word, with a legality flag.
module instr_packer
  import instr_encode_pkg::*;
(
  input  logic [4:0]        op,
  input  fields_t           f,
  output logic [WORD_W-1:0] word,
  output logic              legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (op)
      OP_ADD:  word = r_word(FN_ADD, f.rs, f.rt, f.rd, 5'd0);
      OP_SUB:  word = r_word(FN_SUB, f.rs, f.rt, f.rd, 5'd0);
      OP_AND:  word = r_word(FN_AND, f.rs, f.rt, f.rd, 5'd0);
      OP_OR:   word = r_word(FN_OR,  f.rs, f.rt, f.rd, 5'd0);
      OP_XOR:  word = r_word(FN_XOR, f.rs, f.rt, f.rd, 5'd0);
      OP_NOR:  word = r_word(FN_NOR, f.rs, f.rt, f.rd, 5'd0);
      OP_SLT:  word = r_word(FN_SLT, f.rs, f.rt, f.rd, 5'd0);
      OP_SLL:  word = r_word(FN_SLL, 5'd0, f.rt, f.rd, f.shamt);
      OP_SRL:  word = r_word(FN_SRL, 5'd0, f.rt, f.rd, f.shamt);
      OP_SRA:  word = r_word(FN_SRA, 5'd0, f.rt, f.rd, f.shamt);
      OP_JR:   word = r_word(FN_JR,   f.rs, 5'd0, 5'd0, 5'd0);
      OP_JALR: word = r_word(FN_JALR, f.rs, 5'd0, f.rd, 5'd0);
      OP_ADDI: word = i_word(OPC_ADDI, f.rs, f.rt, f.imm[15:0]);
      OP_ANDI: word = i_word(OPC_ANDI, f.rs, f.rt, f.imm[15:0]);
      OP_ORI:  word = i_word(OPC_ORI,  f.rs, f.rt, f.imm[15:0]);
      OP_XORI: word = i_word(OPC_XORI, f.rs, f.rt, f.imm[15:0]);
      OP_SLTI: word = i_word(OPC_SLTI, f.rs, f.rt, f.imm[15:0]);
      OP_BEQ:  word = i_word(OPC_BEQ,  f.rs, f.rt, f.imm[15:0]);
      OP_BNE:  word = i_word(OPC_BNE,  f.rs, f.rt, f.imm[15:0]);
      OP_LW:   word = i_word(OPC_LW,   f.rs, f.rt, f.imm[15:0]);
      OP_SW:   word = i_word(OPC_SW,   f.rs, f.rt, f.imm[15:0]);
      OP_J:    word = j_word(OPC_J,   f.imm);
      OP_JAL:  word = j_word(OPC_JAL, f.imm);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: accepts symbolic beats, encodes them and writes instruction memory sequentially.
module instr_encode_loader
  import instr_encode_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4:0]          in_op,
  input  logic [4:0]          in_rs,
  input  logic [4:0]          in_rt,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_shamt,
  input  logic [25:0]         in_imm,
  input  logic                in_last,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [WORD_W-1:0]   mem_wdata,
  output logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic                err_op,
  output logic                err_full
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state;
  fields_t           fields;
  logic [WORD_W-1:0] word;
  logic              legal;
  logic              accept;
  logic              last_slot;

  assign fields = '{rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt, imm: in_imm};

  instr_packer u_packer (
    .op    (in_op),
    .f     (fields),
    .word  (word),
    .legal (legal)
  );

  // start has priority over a same-cycle beat, so ready is masked by it
  assign in_ready  = (state == ST_LOAD) && !start;
  assign accept    = in_valid && in_ready;
  assign last_slot = (word_count == CNT_W'(DEPTH - 1));
  assign busy      = (state == ST_LOAD);
  assign done      = (state == ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      err_op     <= 1'b0;
      err_full   <= 1'b0;
    end else begin
      mem_wen <= 1'b0;
      if (start) begin
        state      <= ST_LOAD;
        word_count <= '0;
        err_op     <= 1'b0;
        err_full   <= 1'b0;
      end else if (state == ST_LOAD && accept) begin
        if (legal) begin
          mem_wen    <= 1'b1;
          mem_addr   <= word_count[ADDR_W-1:0];
          mem_wdata  <= word;
          word_count <= word_count + CNT_W'(1);
        end else begin
          err_op <= 1'b1;
        end
        // filling the last slot without in_last ends the load with an error
        if (in_last) begin
          state <= ST_DONE;
        end else if (legal && last_slot) begin
          state    <= ST_DONE;
          err_full <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed and randomized checks of instr_encode_loader against a table-driven encoding model.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start4 = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0;
  logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [25:0] in_imm = '0;

  logic        in_ready, mem_wen, busy, done, err_op, err_full;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  logic        in_ready4, mem_wen4, busy4, done4, err_op4, err_full4;
  logic [1:0]  mem_addr4;
  logic [31:0] mem_wdata4;
  logic [2:0]  word_count4;

  int checks = 0;
  int failures = 0;

  instr_encode_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_last(in_last), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .word_count(word_count), .busy(busy), .done(done),
    .err_op(err_op), .err_full(err_full)
  );

  instr_encode_loader #(.DEPTH(4), .ADDR_W(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(in_valid), .in_ready(in_ready4),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_imm(in_imm), .in_last(in_last), .mem_wen(mem_wen4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .word_count(word_count4), .busy(busy4), .done(done4),
    .err_op(err_op4), .err_full(err_full4)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Mnemonic tables in ADD..JAL order: format class, opcode, funct
  // class 0: R {rs,rt,rd}, 1: shift {rt,rd,shamt}, 2: JR {rs}, 3: JALR {rs,rd}, 4: I, 5: J
  int         kind_tab [23] = '{0,0,0,0,0,0,0, 1,1,1, 2, 3, 4,4,4,4,4,4,4,4,4, 5,5};
  logic [5:0] opc_tab  [23] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b001000, 6'b001100, 6'b001101,
                                6'b001110, 6'b001010, 6'b000100, 6'b000101, 6'b100011,
                                6'b101011, 6'b000010, 6'b000011};
  logic [5:0] fn_tab   [23] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                6'b100111, 6'b101010, 6'b000000, 6'b000010, 6'b000011,
                                6'b001000, 6'b001001, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                                6'b000000, 6'b000000, 6'b000000};

  function automatic logic [32:0] ref_encode(int op, logic [4:0] rs, logic [4:0] rt,
                                             logic [4:0] rd, logic [4:0] sh, logic [25:0] imm);
    logic [5:0] o, fn;
    if (op > 22) return {1'b0, 32'h0};
    o  = opc_tab[op];
    fn = fn_tab[op];
    case (kind_tab[op])
      0:       return {1'b1, o, rs, rt, rd, 5'd0, fn};
      1:       return {1'b1, o, 5'd0, rt, rd, sh, fn};
      2:       return {1'b1, o, rs, 15'd0, fn};
      3:       return {1'b1, o, rs, 5'd0, rd, 5'd0, fn};
      4:       return {1'b1, o, rs, rt, imm[15:0]};
      default: return {1'b1, o, imm};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input bit sel4);
    @(negedge clk);
    if (sel4) start4 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start4 = 1'b0;
  endtask

  // Offers one beat; returns at 1 time unit after the edge that accepted it
  task automatic send(input bit sel4, input int op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [25:0] imm,
                      input bit last, input int budget, output bit acc);
    in_op = 5'(op); in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
    in_last = last; in_valid = 1'b1; acc = 1'b0;
    for (int k = 0; k < budget; k++) begin
      #1;
      if ((sel4 ? in_ready4 : in_ready) === 1'b1) acc = 1'b1;
      @(posedge clk); #1;
      if (acc) break;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    bit          acc;
    logic [32:0] e;
    int          exp_count;
    bit          exp_err;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);  chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_addr", mem_addr, 0);  chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_count", word_count, 0);   chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);          chk("rst_err_op", err_op, 0);
    chk("rst_err_full", err_full, 0);
    rst = 1'b0;

    // Single ADD; shamt input must be ignored
    pulse_start(0);
    chk("start_busy", busy, 1);
    send(0, 0, 5'd1, 5'd2, 5'd3, 5'd17, 26'h0, 0, 4, acc);
    chk("add_acc", acc, 1);  chk("add_wen", mem_wen, 1);
    chk("add_addr", mem_addr, 0);  chk("add_wdata", mem_wdata, 32'h00221820);
    chk("add_count", word_count, 1);

    // Restart inside LOAD, then back-to-back I-type beats
    pulse_start(0);
    chk("restart_count", word_count, 0);
    send(0, 12, 5'd0, 5'd8, 5'd0, 5'd0, 26'h5, 0, 4, acc);
    chk("addi_wdata", mem_wdata, 32'h20080005);  chk("addi_addr", mem_addr, 0);
    send(0, 19, 5'd29, 5'd9, 5'd0, 5'd0, 26'h4, 0, 1, acc);
    chk("lw_b2b_acc", acc, 1);  chk("lw_wen", mem_wen, 1);
    chk("lw_wdata", mem_wdata, 32'h8FA90004);  chk("lw_addr", mem_addr, 1);

    // SLL (rs ignored), J, BEQ with last
    pulse_start(0);
    send(0, 7, 5'd7, 5'd3, 5'd2, 5'd4, 26'h0, 0, 4, acc);
    chk("sll_wdata", mem_wdata, 32'h00031100);
    send(0, 21, 5'd0, 5'd0, 5'd0, 5'd0, 26'h10, 0, 1, acc);
    chk("j_wdata", mem_wdata, 32'h08000010);
    send(0, 17, 5'd1, 5'd2, 5'd0, 5'd0, 26'hFFFF, 1, 1, acc);
    chk("beq_wdata", mem_wdata, 32'h1022FFFF);  chk("beq_addr", mem_addr, 2);
    chk("beq_wen", mem_wen, 1);  chk("last_done", done, 1);  chk("last_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("done_wen_drop", mem_wen, 0);  chk("done_hold_addr", mem_addr, 2);

    // Illegal op between two ADDs; start from DONE also clears errors
    pulse_start(0);
    chk("clear_count", word_count, 0);
    send(0, 0, 5'd4, 5'd5, 5'd6, 5'd0, 26'h0, 0, 4, acc);
    send(0, 31, 5'd1, 5'd1, 5'd1, 5'd1, 26'h1, 0, 1, acc);
    chk("illegal_acc", acc, 1);  chk("illegal_wen", mem_wen, 0);
    chk("illegal_err", err_op, 1);  chk("illegal_count", word_count, 1);
    send(0, 0, 5'd7, 5'd8, 5'd9, 5'd0, 26'h0, 1, 1, acc);
    chk("after_illegal_addr", mem_addr, 1);  chk("after_illegal_count", word_count, 2);
    chk("after_illegal_wdata", mem_wdata, 32'h00E84820);
    pulse_start(0);
    chk("start_clears_err", err_op, 0);
    send(0, 31, 5'd0, 5'd0, 5'd0, 5'd0, 26'h0, 1, 4, acc);
    chk("illegal_last_done", done, 1);  chk("illegal_last_count", word_count, 0);

    // Fill a 4-deep memory without in_last
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      send(1, 1, 5'(i), 5'd1, 5'd2, 5'd0, 26'h0, 0, 4, acc);
      e = ref_encode(1, 5'(i), 5'd1, 5'd2, 5'd0, 26'h0);
      chk("full_acc", acc, 1);  chk("full_wen", mem_wen4, 1);
      chk("full_addr", mem_addr4, i);  chk("full_wdata", mem_wdata4, e[31:0]);
      chk("full_count", word_count4, i + 1);
    end
    chk("full_err", err_full4, 1);  chk("full_done", done4, 1);  chk("full_ready", in_ready4, 0);
    send(1, 1, 5'd9, 5'd9, 5'd9, 5'd0, 26'h0, 0, 3, acc);
    chk("fifth_rejected", acc, 0);  chk("fifth_count", word_count4, 4);
    chk("fifth_wen", mem_wen4, 0);

    // start and in_valid together inside LOAD
    pulse_start(0);
    send(0, 2, 5'd1, 5'd1, 5'd1, 5'd0, 26'h0, 0, 4, acc);
    start = 1'b1; in_valid = 1'b1; in_op = 5'd0;
    #1;
    chk("start_masks_ready", in_ready, 0);
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    chk("start_win_count", word_count, 0);  chk("start_win_wen", mem_wen, 0);
    chk("start_win_busy", busy, 1);

    // Reset with a write in flight
    send(0, 3, 5'd2, 5'd3, 5'd4, 5'd0, 26'h0, 0, 4, acc);
    chk("inflight_wen", mem_wen, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wen", mem_wen, 0);  chk("mid_rst_wdata", mem_wdata, 0);
    chk("mid_rst_count", word_count, 0);  chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    chk("mid_rst_idle_done", done, 0);  chk("mid_rst_ready", in_ready, 0);
    rst = 1'b0;

    // Randomized program
    pulse_start(0);
    exp_count = 0; exp_err = 0;
    for (int i = 0; i < 60; i++) begin
      int          op;
      logic [4:0]  rs, rt, rd, sh;
      logic [25:0] imm;
      op = int'($urandom_range(0, 31));
      rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); sh = 5'($urandom);
      imm = 26'($urandom);
      e = ref_encode(op, rs, rt, rd, sh, imm);
      send(0, op, rs, rt, rd, sh, imm, i == 59, 4, acc);
      chk("rnd_acc", acc, 1);
      if (e[32]) begin
        chk("rnd_wen", mem_wen, 1);  chk("rnd_addr", mem_addr, exp_count);
        chk("rnd_wdata", mem_wdata, e[31:0]);
        exp_count++;
      end else begin
        chk("rnd_no_wen", mem_wen, 0);
        exp_err = 1'b1;
      end
      chk("rnd_count", word_count, exp_count);
    end
    chk("rnd_done", done, 1);  chk("rnd_err_op", err_op, exp_err);
    chk("rnd_err_full", err_full, 0);  chk("rnd_ready", in_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Encoder counterpart to the pipeline's opcode/funct control decoder.
- Accepts symbolic instruction beats over a valid/ready handshake and packs them into 32-bit MIPS words (R/I/J formats).
- Writes each packed word sequentially into instruction memory.
- Used as the program loader ahead of the pipeline and by self-checking benches to build programs.

Parameters:
- DEPTH, 256: instruction memory capacity in words; must be a power of two, at least 2.
- ADDR_W, 8: word-address width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; clears the word counter and errors, then enters LOAD
- in_valid  input  1  beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_op  input  5  mnemonic code (shared package enum)
- in_rs  input  5  rs field
- in_rt  input  5  rt field
- in_rd  input  5  rd field
- in_shamt  input  5  shift amount
- in_imm  input  26  [15:0] imm16 or branch offset; [25:0] jump target
- in_last  input  1  final beat of program
- mem_wen  output  1  instruction memory write strobe
- mem_addr  output  ADDR_W  word address
- mem_wdata  output  32  encoded instruction
- word_count  output  ADDR_W+1  words written since start
- busy  output  1  state==LOAD
- done  output  1  state==DONE
- err_op  output  1  sticky: unsupported in_op seen
- err_full  output  1  sticky: memory filled before in_last

Behaviour:
- Reset: state IDLE; all outputs 0.
- Reset mid-operation discards any registered word; mem_wen is 0 from reset assertion onward.

States:
- IDLE: in_ready=0. start -> LOAD.
- LOAD: in_ready = !start. start re-clears the counter and errors and stays in LOAD.
- DONE: in_ready=0. start -> LOAD.

Handshake and latency:
- Accepting a beat registers the packed word.
- The next cycle drives mem_wen=1, mem_addr=word_count[ADDR_W-1:0] and mem_wdata; word_count increments on that write.
- Back-to-back beats give one write per cycle.
- mem_wen is a single-cycle strobe; mem_addr and mem_wdata hold their last value otherwise.

Encoding (fields at bits 31:26, 25:21, 20:16, 15:11, 10:6, 5:0):
- R-type, opcode 0: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010. Fields rs, rt, rd; shamt=0.
- Shifts: SLL 000000, SRL 000010, SRA 000011. rs=0; fields rt, rd, shamt.
- JR 001000: rs only. JALR 001001: rs and rd. Other fields 0.
- I-type, fields {opcode, rs, rt, imm[15:0]}: ADDI 001000, ANDI 001100, ORI 001101, XORI 001110, SLTI 001010, BEQ 000100, BNE 000101, LW 100011, SW 101011.
- J-type, fields {opcode, imm[25:0]}: J 000010, JAL 000011.
- Field inputs unused by a format are ignored.

Boundaries:
- Unsupported in_op: beat is consumed, nothing is written, word_count is unchanged, err_op is set.
- An unsupported op with in_last still moves the FSM to DONE.
- in_last accepted: next state is DONE. done rises in the same cycle as that beat's mem_wen.
- Full: a write that makes word_count==DEPTH without in_last moves to DONE, sets err_full, and drops in_ready from that cycle.
- The address never wraps.
- start and in_valid in the same cycle: start wins and the beat is not accepted.
- start pulsed in IDLE or DONE clears word_count, err_op and err_full on the next edge.

Decomposition:
- Package instr_encode_pkg holds:
  - the in_op enum, 23 codes (ADD..JAL);
  - the 6-bit opcode and funct localparams;
  - the state enum.
- Sub-module instr_packer: purely combinational, {in_op, fields} -> {word, legal}.
- The top level holds the FSM, the output register and the counter.

Test Plan:
- start, then ADD rd=3 rs=1 rt=2 last=0 -> one cycle later mem_wen=1, addr 0, wdata 0x00221820; word_count=1.
- Back-to-back ADDI rt=8 rs=0 imm=5, then LW rt=9 rs=29 imm=4 -> consecutive writes: 0x20080005 at addr 0, 0x8FA90004 at addr 1.
- SLL rd=2 rt=3 shamt=4, then J imm=0x10, then BEQ rs=1 rt=2 imm=0xFFFF with last=1 -> writes 0x00031100, 0x08000010, 0x1022FFFF. done=1 with the third write; in_ready=0 afterwards.
- Illegal op code 31 between two ADDs -> err_op=1, only two writes, addresses 0 and 1.
- DEPTH=4: five beats without last -> four writes, then err_full=1, done=1, in_ready=0. Fifth beat never accepted.
- Assert rst while a beat is in flight -> no mem_wen; all outputs 0; state IDLE.
- In LOAD, start and in_valid high together -> beat not accepted; word_count=0 on the next cycle.
